alu_control_mc: RTL and testbench

- Registered, multi-cycle-aware ALU control unit for the EX stage.
- Decodes alu_op plus the 11-bit instruction opcode into an ALU control code, covering the base ADD/SUB/AND/ORR/PASS set plus LSL, LSR, MUL and UDIV.
- MUL and UDIV take parametrised latencies. During them the block drops ready_out and holds the operation, and the pipeline stalls on busy.
- Sits between ID/EX register outputs and the ALU; flush from hazard unit aborts in-flight ops.

---
 rtl/alu_control_mc.sv | 79 +++++++
 tb/tb_alu_control_mc.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_control_mc.sv
// alu_control_mc: registered EX-stage ALU control decode with multi-cycle MUL/UDIV sequencing and stall.
module alu_control_mc #(
   parameter int CTRL_W     = 4,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              valid_in,
   output logic              ready_out,
   input  logic [1:0]        alu_op,
   input  logic [10:0]       opcode,
   output logic [CTRL_W-1:0] alu_control,
   output logic              valid_out,
   output logic              busy,
   output logic              illegal_op
);
   localparam int MAXL = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXL + 1);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t          state;
   logic [CW-1:0]   cnt;
   logic [3:0]      rcode, code;
   logic            ill;
   assign ready_out = (state == IDLE);
   always_comb begin
      rcode = {1'b0, opcode[9], opcode[3], opcode[8]};
      code  = 4'b0111;
      ill   = 1'b0;
      if (!alu_op[1]) code = alu_op[0] ? 4'b0111 : 4'b0010;
      else if (opcode == 11'b10011011000) code = 4'b1000;
      else if (opcode == 11'b10011010110) code = 4'b1001;
      else if (opcode == 11'b11010011011) code = 4'b0011;
      else if (opcode == 11'b11010011010) code = 4'b0100;
      else if (rcode inside {4'b0000, 4'b0001, 4'b0010, 4'b0110}) code = rcode;
      else ill = 1'b1;
   end
   // code[3] marks the multi-cycle ops (MUL/UDIV); code[0] picks UDIV
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         alu_control <= '0;
         valid_out   <= 1'b0;
         busy        <= 1'b0;
         illegal_op  <= 1'b0;
         cnt         <= '0;
      end else if (flush) begin
         state      <= IDLE;
         valid_out  <= 1'b0;
         busy       <= 1'b0;
         illegal_op <= 1'b0;
         cnt        <= '0;
      end else if (state == IDLE) begin
         valid_out  <= 1'b0;
         illegal_op <= 1'b0;
         if (valid_in) begin
            alu_control <= CTRL_W'(code);
            if (code[3]) begin
               busy  <= 1'b1;
               cnt   <= code[0] ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
               state <= BUSY;
            end else begin
               valid_out  <= 1'b1;
               illegal_op <= ill;
            end
         end
      end else begin
         valid_out  <= 1'b0;
         illegal_op <= 1'b0;
         cnt        <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            valid_out <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: table vectors, multi-cycle corner sequences and random traffic against a timestamp model.
module tb_alu_control_mc;
   localparam int CW = 6, ML = 4, DL = 8;
   logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0, valid_in = 1'b0;
   logic [1:0] alu_op = '0;
   logic [10:0] opcode = '0;
   logic ready_out, valid_out, busy, illegal_op;
   logic [CW-1:0] alu_control;
   always #5 clk = ~clk;
   alu_control_mc #(.CTRL_W(CW), .MUL_CYCLES(ML), .DIV_CYCLES(DL)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .valid_in(valid_in), .ready_out(ready_out),
      .alu_op(alu_op), .opcode(opcode), .alu_control(alu_control), .valid_out(valid_out),
      .busy(busy), .illegal_op(illegal_op));
   int total = 0, bad = 0, e = 0, done_edge = 0;
   bit pend = 0, evo = 0, eill = 0;
   logic [CW-1:0] ectrl = '0;
   typedef struct {logic [1:0] op; logic [10:0] opc; logic [3:0] ctrl; bit ill;} vec_t;
   vec_t tbl[10];
   function automatic logic [4:0] ref_dec(logic [1:0] op, logic [10:0] opc);
      logic [3:0] f;
      if (op == 2'b00) return 5'h02;
      if (op == 2'b01) return 5'h07;
      case (opc)
         11'b10011011000: return 5'h08;
         11'b10011010110: return 5'h09;
         11'b11010011011: return 5'h03;
         11'b11010011010: return 5'h04;
         default: ;
      endcase
      f = {1'b0, opc[9], opc[3], opc[8]};
      if (f == 4'd0 || f == 4'd1 || f == 4'd2 || f == 4'd6) return {1'b0, f};
      return 5'h17;
   endfunction
   task automatic chk(string n, logic [31:0] a, logic [31:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s t=%0t actual=%0h expected=%0h", n, $time, a, x);
      end
   endtask
   task automatic check_all(string tag);
      chk({tag, ".ctrl"}, 32'(alu_control), 32'(ectrl));
      chk({tag, ".valid"}, 32'(valid_out), 32'(evo));
      chk({tag, ".busy"}, 32'(busy), 32'(pend));
      chk({tag, ".ready"}, 32'(ready_out), 32'(!pend));
      chk({tag, ".ill"}, 32'(illegal_op), 32'(eill));
   endtask
   task automatic tick();
      bit fl, vi;
      logic [4:0] d;
      fl = flush;
      vi = valid_in;
      d = ref_dec(alu_op, opcode);
      @(posedge clk);
      e++;
      evo = 0;
      eill = 0;
      if (fl) pend = 0;
      else if (pend) begin
         if (e == done_edge) begin evo = 1; pend = 0; end
      end else if (vi) begin
         ectrl = CW'(d[3:0]);
         if (d[3]) begin pend = 1; done_edge = e + (d[0] ? DL : ML) - 1; end
         else begin evo = 1; eill = d[4]; end
      end
      #1;
      check_all("cyc");
   endtask
   task automatic issue(logic [1:0] op, logic [10:0] opc);
      alu_op = op; opcode = opc; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
   endtask
   task automatic wait_done(string n, int exp_lat, logic [3:0] exp_ctrl);
      int lat;
      lat = -1;
      for (int i = 1; i <= 20 && lat < 0; i++) begin
         tick();
         if (valid_out) lat = i;
         else chk({n, ".hold"}, 32'(alu_control), 32'(exp_ctrl));
      end
      chk({n, ".lat"}, 32'(lat), 32'(exp_lat));
      chk({n, ".ctrl"}, 32'(alu_control), 32'(exp_ctrl));
   endtask
   initial begin
      int seen;
      tbl[0] = '{2'b00, 11'h000, 4'b0010, 0};
      tbl[1] = '{2'b01, 11'h7ff, 4'b0111, 0};
      tbl[2] = '{2'b10, 11'b10001011000, 4'b0010, 0};
      tbl[3] = '{2'b10, 11'b11001011000, 4'b0110, 0};
      tbl[4] = '{2'b11, 11'b10001010000, 4'b0000, 0};
      tbl[5] = '{2'b10, 11'b10101010000, 4'b0001, 0};
      tbl[6] = '{2'b10, 11'b11010011011, 4'b0011, 0};
      tbl[7] = '{2'b11, 11'b11010011010, 4'b0100, 0};
      tbl[8] = '{2'b10, 11'b11111111111, 4'b0111, 1};
      tbl[9] = '{2'b10, 11'b01100001000, 4'b0111, 1};
      #1;
      check_all("reset");
      @(posedge clk);
      @(posedge clk);
      #3 reset_n = 1'b1;
      valid_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         alu_op = tbl[i].op;
         opcode = tbl[i].opc;
         tick();
         chk($sformatf("tbl%0d.ctrl", i), 32'(alu_control), 32'(tbl[i].ctrl));
         chk($sformatf("tbl%0d.ill", i), 32'(illegal_op), 32'(tbl[i].ill));
         chk($sformatf("tbl%0d.valid", i), 32'(valid_out), 32'd1);
      end
      valid_in = 1'b0;
      tick();
      chk("ill_clear", 32'(illegal_op), 32'd0);
      chk("valid_clear", 32'(valid_out), 32'd0);
      issue(2'b10, 11'b10011011000);
      chk("mul.busy", 32'(busy), 32'd1);
      wait_done("mul", ML - 1, 4'b1000);
      issue(2'b10, 11'b10011010110);
      wait_done("udiv", DL - 1, 4'b1001);
      issue(2'b10, 11'b10011010110);
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush.busy", 32'(busy), 32'd0);
      chk("flush.ready", 32'(ready_out), 32'd1);
      chk("flush.keep", 32'(alu_control), 32'h9);
      seen = 0;
      repeat (12) begin tick(); seen += int'(valid_out); end
      chk("flush.nopulse", 32'(seen), 32'd0);
      issue(2'b10, 11'b11010011011);
      chk("lsl.ctrl", 32'(alu_control), 32'h3);
      chk("lsl.valid", 32'(valid_out), 32'd1);
      issue(2'b10, 11'b10011011000);
      tick();
      #2 reset_n = 1'b0;
      #1;
      pend = 0; ectrl = '0; evo = 0; eill = 0;
      check_all("areset");
      @(posedge clk);
      e++;
      #1 check_all("areset_hold");
      #2 reset_n = 1'b1;
      seen = 0;
      repeat (10) begin tick(); seen += int'(valid_out); end
      chk("areset.nopulse", 32'(seen), 32'd0);
      repeat (400) begin
         case ($urandom_range(0, 5))
            0: opcode = 11'b10011011000;
            1: opcode = 11'b10011010110;
            2: opcode = 11'b11010011011;
            3: opcode = 11'b11010011010;
            4: opcode = tbl[2 + $urandom_range(0, 3)].opc;
            default: opcode = 11'($urandom);
         endcase
         alu_op = 2'($urandom);
         valid_in = ($urandom_range(0, 9) < 7);
         flush = ($urandom_range(0, 19) == 0);
         tick();
      end
      flush = 1'b0;
      valid_in = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
